// File: rtl/fb_rect_fill.sv
// Rectangle / full-plane fill engine: streams one framebuffer write per cycle in raster order.
// State | meaning: IDLE | waiting for a command; FILL | emitting pixels; DONE | one-cycle completion pulse
module fb_rect_fill #(
    parameter int HOLD_LAST = 1
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iCmd_Valid,
    output logic       oCmd_Ready,
    input  logic       iCmd_Op,
    input  logic [7:0] iX0,
    input  logic [7:0] iY0,
    input  logic [7:0] iX1,
    input  logic [7:0] iY1,
    input  logic [8:0] iColor,
    output logic [7:0] write_x,
    output logic [7:0] write_y,
    output logic [2:0] write_r,
    output logic [2:0] write_g,
    output logic [2:0] write_b,
    output logic       oWrite_En,
    output logic       oBusy,
    output logic       oDone
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] xmin, xmax, ymax;
    logic [7:0] n_xmin, n_xmax, n_ymin, n_ymax;

    always_comb begin
        n_xmin = (iX0 < iX1) ? iX0 : iX1;
        n_xmax = (iX0 < iX1) ? iX1 : iX0;
        n_ymin = (iY0 < iY1) ? iY0 : iY1;
        n_ymax = (iY0 < iY1) ? iY1 : iY0;
        if (iCmd_Op) begin
            n_xmin = 8'd0;
            n_xmax = 8'd255;
            n_ymin = 8'd0;
            n_ymax = 8'd255;
        end
    end

    assign oCmd_Ready = (state == ST_IDLE) && !iRST;
    assign oBusy      = (state == ST_FILL);
    assign oDone      = (state == ST_DONE);

    // End of row/plane is detected by equality so a bound of 255 never wraps.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= ST_IDLE;
            write_x   <= 8'd0;
            write_y   <= 8'd0;
            write_r   <= 3'd0;
            write_g   <= 3'd0;
            write_b   <= 3'd0;
            oWrite_En <= 1'b0;
            xmin      <= 8'd0;
            xmax      <= 8'd0;
            ymax      <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iCmd_Valid) begin
                        state     <= ST_FILL;
                        xmin      <= n_xmin;
                        xmax      <= n_xmax;
                        ymax      <= n_ymax;
                        write_x   <= n_xmin;
                        write_y   <= n_ymin;
                        write_r   <= iColor[8:6];
                        write_g   <= iColor[5:3];
                        write_b   <= iColor[2:0];
                        oWrite_En <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (write_x == xmax) begin
                        if (write_y == ymax) begin
                            state     <= ST_DONE;
                            oWrite_En <= 1'b0;
                            if (HOLD_LAST == 0) begin
                                write_x <= 8'd0;
                                write_y <= 8'd0;
                                write_r <= 3'd0;
                                write_g <= 3'd0;
                                write_b <= 3'd0;
                            end
                        end else begin
                            write_x <= xmin;
                            write_y <= write_y + 8'd1;
                        end
                    end else begin
                        write_x <= write_x + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Scoreboard bench for fb_rect_fill: driver queues expected writes/done pulses, monitor pops and compares.
module tb_fb_rect_fill;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iCmd_Valid = 1'b0;
    logic       oCmd_Ready;
    logic       iCmd_Op = 1'b0;
    logic [7:0] iX0 = 8'd0, iY0 = 8'd0, iX1 = 8'd0, iY1 = 8'd0;
    logic [8:0] iColor = 9'd0;
    logic [7:0] write_x, write_y;
    logic [2:0] write_r, write_g, write_b;
    logic       oWrite_En, oBusy, oDone;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       done;
        logic [7:0] x;
        logic [7:0] y;
        logic [8:0] c;
    } ev_t;

    ev_t exp_q[$];

    fb_rect_fill #(.HOLD_LAST(1)) dut (
        .iCLK(iCLK), .iRST(iRST), .iCmd_Valid(iCmd_Valid), .oCmd_Ready(oCmd_Ready),
        .iCmd_Op(iCmd_Op), .iX0(iX0), .iY0(iY0), .iX1(iX1), .iY1(iY1), .iColor(iColor),
        .write_x(write_x), .write_y(write_y), .write_r(write_r), .write_g(write_g),
        .write_b(write_b), .oWrite_En(oWrite_En), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_px(input logic [7:0] x, input logic [7:0] y, input logic [8:0] c);
        ev_t e;
        e.done = 1'b0; e.x = x; e.y = y; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    // Returns at #1 after the accepting edge, i.e. in cycle 1 after acceptance.
    task automatic issue(input logic op, input logic [7:0] x0, input logic [7:0] y0,
                         input logic [7:0] x1, input logic [7:0] y1, input logic [8:0] c);
        int n = 0;
        while (!oCmd_Ready && n < 1000) begin
            @(negedge iCLK);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: ready never seen, got 0 expected 1");
        end
        iCmd_Op = op; iX0 = x0; iY0 = y0; iX1 = x1; iY1 = y1; iColor = c;
        iCmd_Valid = 1'b1;
        @(posedge iCLK);
        #1;
        iCmd_Valid = 1'b0;
    endtask

    // Monitor: every write or done pulse must match the head of the scoreboard.
    initial begin
        ev_t e;
        forever begin
            @(negedge iCLK);
            if (oWrite_En || oDone) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got we=%0d done=%0d at (%0d,%0d) expected nothing",
                             oWrite_En, oDone, write_x, write_y);
                end else begin
                    e = exp_q.pop_front();
                    if (e.done) begin
                        if (!(oDone && !oWrite_En)) begin
                            errors++;
                            $display("FAIL done_event: got we=%0d done=%0d expected we=0 done=1",
                                     oWrite_En, oDone);
                        end
                    end else if (!(oWrite_En && !oDone && write_x == e.x && write_y == e.y &&
                                   {write_r, write_g, write_b} == e.c)) begin
                        errors++;
                        $display("FAIL pixel: got we=%0d done=%0d (%0d,%0d) c=%h expected (%0d,%0d) c=%h",
                                 oWrite_En, oDone, write_x, write_y, {write_r, write_g, write_b},
                                 e.x, e.y, e.c);
                    end
                end
            end
        end
    end

    initial begin
        int cnt;
        // Reset state
        wait_cycles(3);
        chk("rst_we", oWrite_En, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_xy", {write_x, write_y}, 0);
        chk("rst_rgb", {write_r, write_g, write_b}, 0);
        chk("rst_ready_in_reset", oCmd_Ready, 0);
        iRST = 1'b0;
        #1;
        chk("rst_ready_after", oCmd_Ready, 1);

        // Basic fill
        push_px(2, 3, 9'h1C0); push_px(3, 3, 9'h1C0); push_px(4, 3, 9'h1C0);
        push_px(2, 4, 9'h1C0); push_px(3, 4, 9'h1C0); push_px(4, 4, 9'h1C0);
        push_done();
        issue(0, 2, 3, 4, 4, 9'h1C0);
        chk("t1_busy_c1", oBusy, 1);
        chk("t1_ready_c1", oCmd_Ready, 0);
        wait_cycles(6);
        chk("t1_done_c7", oDone, 1);
        chk("t1_busy_c7", oBusy, 0);
        chk("t1_ready_c7", oCmd_Ready, 0);
        wait_cycles(1);
        chk("t1_ready_c8", oCmd_Ready, 1);
        chk("t1_hold_xy", {write_x, write_y}, {8'd4, 8'd4});
        chk("t1_hold_rgb", {write_r, write_g, write_b}, 9'h1C0);

        // Swapped corners
        push_px(2, 3, 9'h1C0); push_px(3, 3, 9'h1C0); push_px(4, 3, 9'h1C0);
        push_px(2, 4, 9'h1C0); push_px(3, 4, 9'h1C0); push_px(4, 4, 9'h1C0);
        push_done();
        issue(0, 4, 4, 2, 3, 9'h1C0);
        wait_cycles(6);
        chk("t2_done_c7", oDone, 1);
        wait_cycles(1);
        chk("t2_ready_c8", oCmd_Ready, 1);

        // Single pixel at the far corner
        push_px(255, 255, 9'h0A5);
        push_done();
        issue(0, 255, 255, 255, 255, 9'h0A5);
        chk("t3_busy_c1", oBusy, 1);
        wait_cycles(1);
        chk("t3_done_c2", oDone, 1);
        wait_cycles(1);
        chk("t3_ready_c3", oCmd_Ready, 1);

        // Clear the whole plane
        for (int y = 0; y < 256; y++)
            for (int x = 0; x < 256; x++)
                push_px(x[7:0], y[7:0], 9'h000);
        push_done();
        issue(1, 5, 6, 7, 8, 9'h000);
        cnt = 0;
        while (oBusy && cnt < 70000) begin
            cnt++;
            wait_cycles(1);
        end
        chk("t4_busy_cycles", cnt, 65536);
        chk("t4_done_after", oDone, 1);
        wait_cycles(1);

        // Command pulsed while busy must be ignored
        push_px(2, 3, 9'h1C0); push_px(3, 3, 9'h1C0); push_px(4, 3, 9'h1C0);
        push_px(2, 4, 9'h1C0); push_px(3, 4, 9'h1C0); push_px(4, 4, 9'h1C0);
        push_done();
        issue(0, 2, 3, 4, 4, 9'h1C0);
        wait_cycles(1);
        iCmd_Op = 1'b1; iX0 = 8'd0; iY0 = 8'd0; iX1 = 8'd9; iY1 = 8'd9; iColor = 9'h03F;
        iCmd_Valid = 1'b1;
        chk("t5_ready_busy", oCmd_Ready, 0);
        wait_cycles(3);
        iCmd_Valid = 1'b0;
        wait_cycles(2);
        chk("t5_done_c7", oDone, 1);
        wait_cycles(1);
        chk("t5_ready_c8", oCmd_Ready, 1);

        // Reset on the 3rd pixel of a 10x10 fill
        push_px(10, 20, 9'h155); push_px(11, 20, 9'h155); push_px(12, 20, 9'h155);
        issue(0, 10, 20, 19, 29, 9'h155);
        wait_cycles(2);
        chk("t6_third_px_x", write_x, 12);
        iRST = 1'b1;
        #1;
        chk("t6_ready_in_rst", oCmd_Ready, 0);
        wait_cycles(1);
        chk("t6_we_after_rst", oWrite_En, 0);
        chk("t6_xy_after_rst", {write_x, write_y}, 0);
        chk("t6_rgb_after_rst", {write_r, write_g, write_b}, 0);
        chk("t6_busy_after_rst", oBusy, 0);
        chk("t6_done_after_rst", oDone, 0);
        iRST = 1'b0;
        #1;
        chk("t6_ready_first", oCmd_Ready, 1);
        push_px(7, 8, 9'h1AB);
        push_done();
        issue(0, 7, 8, 7, 8, 9'h1AB);
        chk("t6_new_busy", oBusy, 1);
        wait_cycles(1);
        chk("t6_new_done", oDone, 1);
        wait_cycles(3);

        cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin
            cnt++;
            wait_cycles(1);
        end
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
